// File: rtl/hamm_seq_if.sv
// Request/result bus for hamm_seq: operand handshake in, popcount result handshake out.
// The master side issues requests and consumes results; the slave side is the sequencer.
interface hamm_seq_if #(
  parameter int NBYTES = 4
);
  logic                  clear;
  logic                  in_valid;
  logic                  in_ready;
  logic                  mode;
  logic [8*NBYTES-1:0]   a;
  logic [8*NBYTES-1:0]   b;
  logic                  out_valid;
  logic                  out_ready;
  logic [5:0]            count;
  logic                  parity;
  logic                  zero;

  modport master (
    output clear, in_valid, mode, a, b, out_ready,
    input  in_ready, out_valid, count, parity, zero
  );

  modport slave (
    input  clear, in_valid, mode, a, b, out_ready,
    output in_ready, out_valid, count, parity, zero
  );
endinterface

// File: rtl/hamm_seq.sv
// Hamming weight / distance sequencer: one 8-bit popcount unit walks the latched
// operand a byte per clock and accumulates the total into a 6-bit count.
module hamm_seq #(
  parameter int NBYTES = 4
) (
  input  logic       clk,
  input  logic       rst,
  hamm_seq_if.slave  bus
);
  localparam int         W    = 8 * NBYTES;
  localparam logic [2:0] LAST = 3'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t       r_state;
  logic [2:0]   r_idx;
  logic [5:0]   r_acc;
  logic [W-1:0] r_op;
  logic         r_in_ready;
  logic         r_out_valid;
  logic [5:0]   r_count;
  logic         r_parity;
  logic         r_zero;

  logic [7:0]   w_byte;
  logic [3:0]   w_pop;
  logic [5:0]   w_sum;

  // Byte lane selected by the running index feeds the single shared popcount unit.
  always_comb begin
    w_byte = '0;
    for (int i = 0; i < NBYTES; i++) begin
      if (r_idx == 3'(i)) w_byte = r_op[i*8 +: 8];
    end
  end

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < 8; i++) begin
      w_pop = w_pop + {3'b000, w_byte[i]};
    end
  end

  assign w_sum = r_acc + {2'b00, w_pop};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_acc       <= '0;
      r_op        <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_count     <= '0;
      r_parity    <= 1'b0;
      r_zero      <= 1'b1;
    end else if (bus.clear) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_acc       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_count     <= '0;
      r_parity    <= 1'b0;
      r_zero      <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_op       <= bus.mode ? (bus.a ^ bus.b) : bus.a;
            r_acc      <= '0;
            r_idx      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= RUN;
          end
        end
        RUN: begin
          r_acc <= w_sum;
          if (r_idx == LAST) begin
            r_idx       <= '0;
            r_out_valid <= 1'b1;
            r_count     <= w_sum;
            r_parity    <= w_sum[0];
            r_zero      <= (w_sum == 6'd0);
            r_state     <= DONE;
          end else begin
            r_idx <= r_idx + 3'd1;
          end
        end
        DONE: begin
          // Result stays frozen until taken; re-acceptance waits for the next cycle.
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_count     <= '0;
            r_parity    <= 1'b0;
            r_zero      <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.count     = r_count;
  assign bus.parity    = r_parity;
  assign bus.zero      = r_zero;
endmodule

// File: tb/tb_hamm_seq.sv
// Bench for hamm_seq: transaction-level model checked every cycle on the 4-byte
// instance, plus directed literal checks on both a 4-byte and a 1-byte instance.
module tb_hamm_seq;
  logic clk;
  logic rst;

  hamm_seq_if #(.NBYTES(4)) b4();
  hamm_seq_if #(.NBYTES(1)) b1();

  hamm_seq #(.NBYTES(4)) u_dut4 (.clk(clk), .rst(rst), .bus(b4));
  hamm_seq #(.NBYTES(1)) u_dut1 (.clk(clk), .rst(rst), .bus(b1));

  int n_checks = 0;
  int n_errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: idle / busy for NBYTES edges / holding a result.
  int m_phase;   // 0 idle, 1 busy, 2 result held
  int m_left;
  int m_res;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0;
      m_left  = 0;
      m_res   = 0;
    end else if (b4.clear) begin
      m_phase = 0;
    end else if (m_phase == 0) begin
      if (b4.in_valid) begin
        m_res   = b4.mode ? $countones(b4.a ^ b4.b) : $countones(b4.a);
        m_left  = 4;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      m_left = m_left - 1;
      if (m_left == 0) m_phase = 2;
    end else if (b4.out_ready) begin
      m_phase = 0;
    end
  end

  always @(negedge clk) begin
    int exp_cnt;
    exp_cnt = (m_phase == 2) ? m_res : 0;
    check("model in_ready",  32'(b4.in_ready),  32'(m_phase == 0));
    check("model out_valid", 32'(b4.out_valid), 32'(m_phase == 2));
    check("model count",     32'(b4.count),     32'(exp_cnt));
    check("model parity",    32'(b4.parity),    32'(exp_cnt % 2));
    check("model zero",      32'(b4.zero),      32'(exp_cnt == 0));
  end

  task automatic send4(input logic md, input logic [31:0] av, input logic [31:0] bv);
    b4.mode = md;
    b4.a = av;
    b4.b = bv;
    b4.in_valid = 1'b1;
    @(negedge clk);
    b4.in_valid = 1'b0;
    b4.a = $urandom;
    b4.b = $urandom;
    b4.mode = ~md;
  endtask

  task automatic wait4(output int n);
    n = 0;
    while (!b4.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run4(input string name, input logic md, input logic [31:0] av,
                      input logic [31:0] bv, input int exp);
    int n;
    send4(md, av, bv);
    wait4(n);
    check({name, " latency"}, 32'(n), 32'd4);
    check({name, " count"},   32'(b4.count),  32'(exp));
    check({name, " parity"},  32'(b4.parity), 32'(exp % 2));
    check({name, " zero"},    32'(b4.zero),   32'(exp == 0));
    b4.out_ready = 1'b1;
    @(negedge clk);
    b4.out_ready = 1'b0;
    check({name, " back to idle"}, 32'(b4.in_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    b4.clear = 0; b4.in_valid = 0; b4.mode = 0; b4.a = 0; b4.b = 0; b4.out_ready = 0;
    b1.clear = 0; b1.in_valid = 0; b1.mode = 0; b1.a = 0; b1.b = 0; b1.out_ready = 0;
    #1;
    check("reset in_ready",  32'(b4.in_ready),  32'd1);
    check("reset out_valid", 32'(b4.out_valid), 32'd0);
    check("reset count",     32'(b4.count),     32'd0);
    check("reset zero",      32'(b4.zero),      32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run4("ones",     1'b0, 32'hFFFF_FFFF, 32'h0,          32);
    run4("distance", 1'b1, 32'h0F0F_0F0F, 32'h00FF_00FF,  16);
    run4("edges",    1'b0, 32'h8000_0001, 32'h0,           2);
    run4("allzero",  1'b0, 32'h0000_0000, 32'hFFFF_FFFF,   0);
    run4("seven",    1'b0, 32'h0000_0007, 32'h0,           3);

    // Result held while the consumer stalls and new requests are offered.
    send4(1'b0, 32'h0000_00FF, 32'h0);
    wait4(n);
    check("hold latency", 32'(n), 32'd4);
    b4.in_valid = 1'b1;
    b4.mode = 1'b0;
    b4.a = 32'hFFFF_FFFF;
    repeat (3) begin
      @(negedge clk);
      check("hold count",     32'(b4.count),     32'd8);
      check("hold in_ready",  32'(b4.in_ready),  32'd0);
      check("hold out_valid", 32'(b4.out_valid), 32'd1);
    end
    b4.out_ready = 1'b1;
    @(negedge clk);
    b4.out_ready = 1'b0;
    check("release idle", 32'(b4.in_ready), 32'd1);
    @(negedge clk);
    b4.in_valid = 1'b0;
    check("reaccept busy", 32'(b4.in_ready), 32'd0);
    wait4(n);
    check("reaccept latency", 32'(n), 32'd4);
    check("reaccept count", 32'(b4.count), 32'd32);
    b4.out_ready = 1'b1;
    @(negedge clk);
    b4.out_ready = 1'b0;

    // Abort in the second RUN cycle.
    send4(1'b1, 32'hFFFF_0000, 32'h0000_FFFF);
    @(negedge clk);
    b4.clear = 1'b1;
    @(negedge clk);
    b4.clear = 1'b0;
    check("clear idle",      32'(b4.in_ready),  32'd1);
    check("clear out_valid", 32'(b4.out_valid), 32'd0);
    n = 0;
    repeat (6) begin
      @(negedge clk);
      if (b4.out_valid) n++;
    end
    check("clear no result", 32'(n), 32'd0);
    b4.clear = 1'b1;
    b4.in_valid = 1'b1;
    @(negedge clk);
    b4.clear = 1'b0;
    b4.in_valid = 1'b0;
    check("clear beats in_valid", 32'(b4.in_ready), 32'd1);
    @(negedge clk);
    check("clear still idle", 32'(b4.in_ready), 32'd1);
    run4("after clear", 1'b0, 32'h1234_5678, 32'h0, 13);

    // Asynchronous reset in the middle of RUN.
    send4(1'b0, 32'hFFFF_FFFF, 32'h0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async in_ready",  32'(b4.in_ready),  32'd1);
    check("async out_valid", 32'(b4.out_valid), 32'd0);
    check("async count",     32'(b4.count),     32'd0);
    check("async parity",    32'(b4.parity),    32'd0);
    check("async zero",      32'(b4.zero),      32'd1);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    repeat (8) begin
      @(negedge clk);
      if (b4.out_valid) n++;
    end
    check("no pulse after reset", 32'(n), 32'd0);
    run4("after reset", 1'b0, 32'h0000_0007, 32'h0, 3);

    // Single-byte instance.
    b1.mode = 1'b0;
    b1.a = 8'hA5;
    b1.in_valid = 1'b1;
    @(negedge clk);
    b1.in_valid = 1'b0;
    n = 0;
    while (!b1.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("nb1 latency", 32'(n), 32'd1);
    check("nb1 count",   32'(b1.count),  32'd4);
    check("nb1 parity",  32'(b1.parity), 32'd0);
    check("nb1 zero",    32'(b1.zero),   32'd0);
    b1.out_ready = 1'b1;
    @(negedge clk);
    b1.out_ready = 1'b0;
    check("nb1 idle", 32'(b1.in_ready), 32'd1);

    b1.mode = 1'b1;
    b1.a = 8'hA5;
    b1.b = 8'h01;
    b1.in_valid = 1'b1;
    @(negedge clk);
    b1.in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("nb1 async in_ready",  32'(b1.in_ready),  32'd1);
    check("nb1 async out_valid", 32'(b1.out_valid), 32'd0);
    check("nb1 async zero",      32'(b1.zero),      32'd1);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    repeat (4) begin
      @(negedge clk);
      if (b1.out_valid) n++;
    end
    check("nb1 no pulse", 32'(n), 32'd0);
    b1.in_valid = 1'b1;
    @(negedge clk);
    b1.in_valid = 1'b0;
    n = 0;
    while (!b1.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("nb1 dist latency", 32'(n), 32'd1);
    check("nb1 dist count",   32'(b1.count),  32'd3);
    check("nb1 dist parity",  32'(b1.parity), 32'd1);
    b1.out_ready = 1'b1;
    @(negedge clk);
    b1.out_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
